// File: rtl/serial_rx.sv
`timescale 1ns/1ps
// serial_rx -- memory-mapped UART receiver (8N1), receive-side counterpart
// of the Serial output device.
//
// The asynchronous rx line is oversampled. Each received byte goes into a
// show-ahead FIFO. The CPU reads two words on the dmem read path:
//   addr[2] = 0  DATA   {23'b0, valid, byte}   a read pops the FIFO head
//   addr[2] = 1  STATUS {16'b0, count[7:0], 4'b0, ferr, ovr, full, !empty}
//                a read clears ferr and ovr
//
// Ports
//   clock  in   1   system clock
//   reset  in   1   synchronous, active-high
//   rx     in   1   asynchronous serial line, idle high
//   sel    in   1   device selected by the Mmu
//   re     in   1   CPU read enable
//   addr   in  32   byte address; only addr[2] is decoded
//   dout   out 32   read data, combinational from addr and current state
module serial_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic        sel,
  input  logic        re,
  input  logic [31:0] addr,
  output logic [31:0] dout
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW      = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer and falling-edge detector
  // ---------------------------------------------------------------------
  logic       rx_meta_reg;
  logic       rx_sync_reg;
  logic       rx_prev_reg;
  logic [1:0] fill_reg;
  logic       fall;

  // fill_reg marks when the synchronizer holds real line samples, not its
  // reset value. Until then rx_prev stays 0. A line that is low at or
  // after reset therefore never looks like a 1->0 edge. It has to be seen
  // high first.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      fill_reg    <= 2'b00;
      rx_prev_reg <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      fill_reg    <= {fill_reg[0], 1'b1};
      rx_prev_reg <= fill_reg[1] & rx_sync_reg;
    end
  end

  assign fall = rx_prev_reg & ~rx_sync_reg;

  // ---------------------------------------------------------------------
  // Receive FSM with baud-tick generator
  // ---------------------------------------------------------------------
  state_t         state_reg, state_next;
  logic [DW-1:0]  div_cnt_reg, div_cnt_next;
  logic [OW-1:0]  tick_cnt_reg, tick_cnt_next;
  logic [2:0]     bit_idx_reg, bit_idx_next;
  logic [7:0]     shift_reg, shift_next;
  logic           tick;
  logic           push_req;
  logic           ferr_set;

  assign tick = (div_cnt_reg == DW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      div_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = tick ? '0 : div_cnt_reg + DW'(1);
    tick_cnt_next = tick ? tick_cnt_reg + OW'(1) : tick_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    push_req      = 1'b0;
    ferr_set      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Both counters are held at 0, so every frame starts its timing
        // from the detected edge.
        div_cnt_next  = '0;
        tick_cnt_next = '0;
        if (fall) begin
          state_next = S_START;
        end
      end

      S_START: begin
        // Check the middle of the start bit. A high line here was only a
        // glitch, so go back to IDLE.
        if (tick && tick_cnt_reg == OW'(OVERSAMPLE / 2 - 1)) begin
          tick_cnt_next = '0;
          if (!rx_sync_reg) begin
            state_next   = S_DATA;
            bit_idx_next = '0;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (tick && tick_cnt_reg == OW'(OVERSAMPLE - 1)) begin
          tick_cnt_next = '0;
          // LSB first: shift right, new bit in at the top.
          shift_next    = {rx_sync_reg, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (tick && tick_cnt_reg == OW'(OVERSAMPLE - 1)) begin
          state_next = S_IDLE;
          if (rx_sync_reg) begin
            push_req = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO, error flags and CPU read port
  // ---------------------------------------------------------------------
  logic [7:0]    mem_reg [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovr_reg;
  logic          ferr_reg;

  logic          empty;
  logic          full;
  logic          data_rd;
  logic          stat_rd;
  logic          pop;
  logic          push;
  logic          ovr_set;
  logic [7:0]    head_byte;
  logic [7:0]    count8;
  logic          unused_addr;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign data_rd = sel & re & ~addr[2];
  assign stat_rd = sel & re & addr[2];
  assign pop     = data_rd & ~empty;
  // A pop in the same cycle frees the slot the push writes into. That
  // holds even when the FIFO is full, so no overrun is flagged then.
  assign push    = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovr_reg    <= 1'b0;
      ferr_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // If a flag is set in the same cycle as a STATUS read clears it,
      // the set wins.
      if (ovr_set) begin
        ovr_reg <= 1'b1;
      end else if (stat_rd) begin
        ovr_reg <= 1'b0;
      end
      if (ferr_set) begin
        ferr_reg <= 1'b1;
      end else if (stat_rd) begin
        ferr_reg <= 1'b0;
      end
    end
  end

  assign head_byte   = empty ? 8'h00 : mem_reg[rd_ptr_reg];
  assign count8      = 8'(count_reg);
  assign unused_addr = ^{addr[31:3], addr[1:0]};

  always_comb begin
    dout = '0;
    if (!addr[2]) begin
      dout = {23'b0, ~empty, head_byte};
    end else begin
      dout = {16'b0, count8, 4'b0, ferr_reg, ovr_reg, full, ~empty};
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
`timescale 1ns/1ps
module tb_serial_rx;

  // The bit rate is scaled down so the run stays short. DIV truncates
  // (5e6 / 1.6e6 = 3.125 -> 3), which also exercises the truncation.
  localparam int CLK_FREQ = 5000000;
  localparam int BAUD     = 100000;
  localparam int OS       = 16;
  localparam int DEPTH    = 16;
  localparam int BIT      = (CLK_FREQ / (BAUD * OS)) * OS;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        sel   = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] dout;

  serial_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx   (rx),
    .sel  (sel),
    .re   (re),
    .addr (addr),
    .dout (dout)
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the byte queue plus the two sticky flags.
  byte unsigned model_q[$];
  bit           m_ovr  = 1'b0;
  bit           m_ferr = 1'b0;

  // Line waveform, one entry per clock. When the queue is empty the line
  // sits at idle_level.
  bit   wave_q[$];
  logic idle_level = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    if (model_q.size() == 0) return 32'h0;
    return {23'b0, 1'b1, model_q[0]};
  endfunction

  function automatic logic [31:0] exp_status();
    logic [7:0] c;
    c = 8'(model_q.size());
    return {16'b0, c, 4'b0, m_ferr, m_ovr, (model_q.size() == DEPTH), (model_q.size() != 0)};
  endfunction

  function automatic void model_frame(input byte unsigned b, input bit stop);
    if (!stop) m_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  task automatic step();
    @(negedge clock);
    rx = (wave_q.size() > 0) ? wave_q.pop_front() : idle_level;
  endtask

  task automatic queue_frame(input byte unsigned b, input bit stop);
    repeat (BIT) wave_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (BIT) wave_q.push_back(b[i]);
    repeat (BIT) wave_q.push_back(stop);
  endtask

  task automatic send_frame(input byte unsigned b, input bit stop);
    queue_frame(b, stop);
    while (wave_q.size() > 0) step();
    repeat (BIT) step();
    model_frame(b, stop);
  endtask

  task automatic read_data(input string tag);
    sel = 1'b1; re = 1'b1; addr = 32'h0;
    #1;
    check(tag, dout, exp_data());
    if (model_q.size() > 0) void'(model_q.pop_front());
    step();
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic read_status(input string tag);
    sel = 1'b1; re = 1'b1; addr = 32'h4;
    #1;
    check(tag, dout, exp_status());
    m_ovr = 1'b0; m_ferr = 1'b0;
    step();
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [31:0] a);
    sel = 1'b0; re = 1'b0; addr = a;
    #1;
    check(tag, dout, a[2] ? exp_status() : exp_data());
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    bit          found;
    byte unsigned nb;
    int          nreads;

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    peek("reset_data", 32'h0);
    peek("reset_status", 32'h4);
    repeat (4) step();

    // 0x5A: measure cycles from start bit until the byte shows in STATUS
    queue_frame(8'h5A, 1'b1);
    sel = 1'b0; re = 1'b0; addr = 32'h4;
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 12 * BIT && !found; k++) begin
      step();
      #1;
      if (dout[15:8] != 8'h00) begin
        found = 1'b1;
        lat = k;
      end
    end
    // Visible within a few clocks after the middle of the stop bit
    check("t1_latency", 32'(found && lat >= (BIT * 19) / 2 && lat <= (BIT * 19) / 2 + 8), 32'd1);
    while (wave_q.size() > 0) step();
    repeat (BIT) step();
    model_frame(8'h5A, 1'b1);
    read_status("t1_status");
    // re without sel: dout still driven, nothing popped
    sel = 1'b0; re = 1'b1; addr = 32'h0;
    #1;
    check("t1_nosel_data", dout, exp_data());
    step();
    re = 1'b0;
    read_status("t1_status_kept");
    read_data("t1_data");
    read_status("t1_status_empty");
    read_data("t1_data_empty");

    // 16 bytes fill the FIFO; 0x10 overruns
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    send_frame(8'h10, 1'b1);
    read_status("t2_status_full_ovr");
    for (int i = 0; i < 16; i++) read_data("t2_data");
    read_status("t2_status_after");

    // Start-bit glitch, 5 clocks low
    repeat (5) wave_q.push_back(1'b0);
    repeat (3 * BIT) step();
    read_status("glitch_status");
    peek("glitch_data", 32'h0);

    // Framing error, then a clean byte
    send_frame(8'h33, 1'b0);
    read_status("ferr_status");
    read_status("ferr_status_cleared");
    send_frame(8'h44, 1'b1);
    read_data("ferr_next_data");

    // Full FIFO; DATA read lands on the push edge of a new byte
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    nb = 8'($urandom_range(0, 255));
    queue_frame(nb, 1'b1);
    repeat (lat - 1) step();
    sel = 1'b1; re = 1'b1; addr = 32'h0;
    #1;
    check("coinc_head", dout, exp_data());
    if (model_q.size() > 0) void'(model_q.pop_front());
    step();
    sel = 1'b0; re = 1'b0;
    while (wave_q.size() > 0) step();
    repeat (BIT) step();
    model_frame(nb, 1'b1);
    read_status("coinc_status");
    for (int i = 0; i < DEPTH; i++) read_data("coinc_drain");

    // Reset in the DATA state of 0xA5, line held low 3 bits after release
    send_frame(8'h77, 1'b1);
    queue_frame(8'hA5, 1'b1);
    repeat (3 * BIT + BIT / 2) step();
    wave_q.delete();
    idle_level = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    model_q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0;
    peek("rst_status", 32'h4);
    peek("rst_data", 32'h0);
    repeat (3 * BIT) step();
    idle_level = 1'b1;
    repeat (2 * BIT) step();
    read_status("rst_no_byte");
    send_frame(8'h81, 1'b1);
    read_data("rst_data_81");

    // Random frames, some with a bad stop bit, and random reads
    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0));
      nreads = $urandom_range(0, 2);
      for (int r = 0; r < nreads; r++) begin
        if ($urandom_range(0, 1) == 0) read_data("rnd_data");
        else read_status("rnd_status");
      end
    end
    read_status("rnd_final_status");
    for (int i = 0; i < DEPTH && model_q.size() > 0; i++) read_data("rnd_drain");
    read_data("rnd_final_empty");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
